// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one fifo write port among NREQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add per-requester beat counters and a stall counter.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 32,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 8,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      fifo_wr_data,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   output logic                  grant_valid,
   output logic [IDW-1:0]        grant_id
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NREQ*32-1:0]    stat_beats,
   output logic [31:0]           stat_stall
`endif
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

   logic           accept;
   logic           found_idle, found_next;
   logic [IDW-1:0] pick_idle, pick_next;
   logic [IDW-1:0] next_ptr;

   // Returns {found, index} of the first valid requester scanning from ptr with wrap.
   function automatic logic [IDW:0] pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
      logic [IDW:0] res;
      int unsigned  idx;
      res = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (!res[IDW] && valid[idx]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      accept       = 1'b0;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      grant_valid  = 1'b0;
      fifo_wr_data = req_data[owner_q*WIDTH +: WIDTH];
      next_ptr     = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
      {found_idle, pick_idle} = pick(req_valid, rr_ptr_q);
      {found_next, pick_next} = pick(req_valid, next_ptr);

      case (state_q)
         IDLE: begin
            if (found_idle) begin
               state_d    = GRANT;
               owner_d    = pick_idle;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            grant_valid        = 1'b1;
            accept             = req_valid[owner_q] & ~fifo_full;
            fifo_wr_en         = accept;
            req_ready[owner_q] = ~fifo_full;
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            if (!req_valid[owner_q] ||
                (accept && (req_last[owner_q] || beat_cnt_q == CW'(MAX_BURST - 1)))) begin
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
               // The scan from owner+1 only lands on the owner when nobody else is valid.
               if (found_next && pick_next != owner_q) owner_d = pick_next;
               else state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign grant_id = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [NREQ-1:0][31:0] stat_beats_q, stat_beats_d;
   logic [31:0]           stat_stall_q, stat_stall_d;

   always_comb begin
      stat_beats_d = stat_beats_q;
      stat_stall_d = stat_stall_q;
      if (accept) stat_beats_d[owner_q] = stat_beats_q[owner_q] + 32'd1;
      if (grant_valid && req_valid[owner_q] && fifo_full) stat_stall_d = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_beats_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_beats_q <= stat_beats_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_beats = stat_beats_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a reference model.
// Define FIFO_WR_ARB_STATS_EN to also exercise the statistics counters.
module tb_fifo_wr_arbiter;
   localparam int WIDTH     = 32;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 8;
   localparam int IDW       = $clog2(NREQ);

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_last;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      fifo_wr_data;
   logic                  fifo_wr_en;
   logic                  fifo_full;
   logic                  grant_valid;
   logic [IDW-1:0]        grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NREQ*32-1:0]    stat_beats;
   logic [31:0]           stat_stall;
`endif

   always #5 clock = ~clock;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_full    (fifo_full),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stat_beats   (stat_beats),
      .stat_stall   (stat_stall)
`endif
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Per-requester pending beats {last, data}; head is driven while not held off.
   logic [WIDTH:0]           q [NREQ][$];
   logic [NREQ-1:0]          hold;
   logic                     full_next;
   logic                     obs_gv, obs_en;
   logic [IDW-1:0]           obs_id;
   logic [WIDTH-1:0]         obs_data;
   logic [NREQ-1:0]          obs_ready;
   logic [IDW+WIDTH-1:0]     wlog [$];

   task automatic drive_inputs();
      logic [WIDTH:0] b;
      fifo_full = full_next;
      for (int i = 0; i < NREQ; i++) begin
         if (q[i].size() > 0 && !hold[i]) begin
            b = q[i][0];
            req_valid[i] = 1'b1;
            req_last[i]  = b[WIDTH];
            req_data[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'($urandom);
            req_data[i*WIDTH +: WIDTH] = $urandom;
         end
      end
   endtask

   task automatic sample();
      obs_gv    = grant_valid;
      obs_en    = fifo_wr_en;
      obs_id    = grant_id;
      obs_data  = fifo_wr_data;
      obs_ready = req_ready;
   endtask

   task automatic run_cycle();
      @(negedge clock);
      drive_inputs();
      #1;
      sample();
      if (obs_en === 1'b1) wlog.push_back({obs_id, obs_data});
      @(posedge clock);
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i] && obs_ready[i] === 1'b1) void'(q[i].pop_front());
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      full_next = 1'b0;
      hold      = '0;
      for (int i = 0; i < NREQ; i++) q[i].delete();
      wlog.delete();
      drive_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      full_next = 1'b0;
      hold      = '0;
      q[1].push_back({1'b0, 32'h1});
      drive_inputs();
      repeat (3) @(negedge clock);
      #1;
      sample();
      tests_run++;
      if (obs_gv !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_valid: got %b expected 0", obs_gv); end
      tests_run++;
      if (obs_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", obs_en); end
      tests_run++;
      if (obs_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", obs_ready); end
      tests_run++;
      if (obs_id !== '0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d expected 0", obs_id); end
   endtask

   task automatic test_single();
      logic act;
      do_reset();
      q[2].push_back({1'b0, 32'hA});
      q[2].push_back({1'b0, 32'hB});
      q[2].push_back({1'b1, 32'hC});
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         act = (c >= 1 && c <= 3);
         tests_run++;
         if (obs_gv !== act || obs_en !== act ||
             (act && (obs_id !== 2'd2 || obs_data !== 32'hA + 32'(c - 1) || obs_ready !== 4'b0100))) begin
            tests_failed++;
            $display("FAIL single c%0d: gv=%b en=%b id=%0d data=%h ready=%b expected gv=%b en=%b id=2 data=%h ready=0100",
                     c, obs_gv, obs_en, obs_id, obs_data, obs_ready, act, act, 32'hA + 32'(c - 1));
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_id [6] = '{0, 0, 1, 1, 3, 3};
      int exp_dt [6] = '{'h10, 'h11, 'h20, 'h21, 'h30, 'h31};
      logic act;
      do_reset();
      q[0].push_back({1'b0, 32'h10}); q[0].push_back({1'b1, 32'h11});
      q[1].push_back({1'b0, 32'h20}); q[1].push_back({1'b1, 32'h21});
      q[3].push_back({1'b0, 32'h30}); q[3].push_back({1'b1, 32'h31});
      for (int c = 0; c < 9; c++) begin
         run_cycle();
         act = (c >= 1 && c <= 6);
         tests_run++;
         if (obs_gv !== act) begin
            tests_failed++;
            $display("FAIL rr_grant_valid c%0d: got %b expected %b", c, obs_gv, act);
         end
      end
      tests_run++;
      if (wlog.size() != 6) begin
         tests_failed++;
         $display("FAIL rr_write_count: got %0d expected 6", wlog.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (wlog[k] !== {IDW'(exp_id[k]), 32'(exp_dt[k])}) begin
               tests_failed++;
               $display("FAIL rr_write%0d: got id=%0d data=%h expected id=%0d data=%h",
                        k, wlog[k][IDW+WIDTH-1:WIDTH], wlog[k][WIDTH-1:0], exp_id[k], exp_dt[k]);
            end
         end
      end
   endtask

   task automatic test_max_burst();
      logic [IDW+WIDTH-1:0] exp;
      do_reset();
      for (int k = 0; k < 20; k++) q[0].push_back({1'b0, 32'h100 + 32'(k)});
      q[1].push_back({1'b0, 32'h200});
      q[1].push_back({1'b1, 32'h201});
      for (int c = 0; c < 20; c++) run_cycle();
      tests_run++;
      if (obs_gv !== 1'b0) begin
         tests_failed++;
         $display("FAIL burst_release_idle: got gv=%b expected 0", obs_gv);
      end
      tests_run++;
      if (wlog.size() != 18) begin
         tests_failed++;
         $display("FAIL burst_write_count: got %0d expected 18", wlog.size());
      end else begin
         for (int k = 0; k < 18; k++) begin
            if (k < 8)       exp = {IDW'(0), 32'h100 + 32'(k)};
            else if (k < 10) exp = {IDW'(1), 32'h200 + 32'(k - 8)};
            else             exp = {IDW'(0), 32'h100 + 32'(k - 2)};
            tests_run++;
            if (wlog[k] !== exp) begin
               tests_failed++;
               $display("FAIL burst_write%0d: got %h expected %h", k, wlog[k], exp);
            end
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      for (int k = 0; k < 4; k++) q[1].push_back({k == 3, 32'h40 + 32'(k)});
      for (int c = 0; c < 11; c++) begin
         full_next = (c >= 2 && c <= 6);
         run_cycle();
         if (c >= 2 && c <= 6) begin
            tests_run++;
            if (obs_en !== 1'b0 || obs_ready !== '0 || obs_gv !== 1'b1 || obs_id !== 2'd1) begin
               tests_failed++;
               $display("FAIL stall c%0d: en=%b ready=%b gv=%b id=%0d expected en=0 ready=0000 gv=1 id=1",
                        c, obs_en, obs_ready, obs_gv, obs_id);
            end
         end
      end
      full_next = 1'b0;
      tests_run++;
      if (obs_gv !== 1'b0) begin tests_failed++; $display("FAIL stall_end_idle: got gv=%b expected 0", obs_gv); end
      tests_run++;
      if (wlog.size() != 4) begin
         tests_failed++;
         $display("FAIL stall_write_count: got %0d expected 4", wlog.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (wlog[k] !== {IDW'(1), 32'h40 + 32'(k)}) begin
               tests_failed++;
               $display("FAIL stall_write%0d: got %h expected %h", k, wlog[k], {IDW'(1), 32'h40 + 32'(k)});
            end
         end
      end
   endtask

   task automatic test_drop_valid();
      do_reset();
      for (int k = 0; k < 3; k++) q[2].push_back({1'b0, 32'h70 + 32'(k)});
      q[3].push_back({1'b1, 32'h80});
      run_cycle();
      run_cycle();
      hold[2] = 1'b1;
      run_cycle();
      tests_run++;
      if (obs_gv !== 1'b1 || obs_id !== 2'd2 || obs_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_cycle: gv=%b id=%0d en=%b expected gv=1 id=2 en=0", obs_gv, obs_id, obs_en);
      end
      run_cycle();
      tests_run++;
      if (obs_gv !== 1'b1 || obs_id !== 2'd3 || obs_en !== 1'b1 || obs_data !== 32'h80) begin
         tests_failed++;
         $display("FAIL drop_handover: gv=%b id=%0d en=%b data=%h expected gv=1 id=3 en=1 data=00000080",
                  obs_gv, obs_id, obs_en, obs_data);
      end
      run_cycle();
      tests_run++;
      if (obs_gv !== 1'b0) begin tests_failed++; $display("FAIL drop_idle: got gv=%b expected 0", obs_gv); end
      hold = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      q[2].push_back({1'b1, 32'h60});
      run_cycle();
      run_cycle();
      for (int k = 0; k < 4; k++) q[0].push_back({k == 3, 32'h50 + 32'(k)});
      run_cycle();
      run_cycle();
      @(negedge clock);
      drive_inputs();
      #1;
      sample();
      tests_run++;
      if (obs_en !== 1'b1 || obs_id !== 2'd0 || obs_data !== 32'h51) begin
         tests_failed++;
         $display("FAIL midrst_beat2: en=%b id=%0d data=%h expected en=1 id=0 data=00000051", obs_en, obs_id, obs_data);
      end
      reset = 1'b1;
      #1;
      sample();
      tests_run++;
      if (obs_en !== 1'b0 || obs_gv !== 1'b0 || obs_ready !== '0 || obs_id !== '0) begin
         tests_failed++;
         $display("FAIL midrst_async: en=%b gv=%b ready=%b id=%0d expected all 0", obs_en, obs_gv, obs_ready, obs_id);
      end
      @(negedge clock);
      reset = 1'b0;
      q[0].delete();
      wlog.delete();
      q[1].push_back({1'b1, 32'h90});
      q[3].push_back({1'b1, 32'hA0});
      drive_inputs();
      run_cycle();
      tests_run++;
      if (obs_gv !== 1'b1 || obs_id !== 2'd1 || obs_en !== 1'b1 || obs_data !== 32'h90) begin
         tests_failed++;
         $display("FAIL midrst_rr_ptr: gv=%b id=%0d en=%b data=%h expected gv=1 id=1 en=1 data=00000090",
                  obs_gv, obs_id, obs_en, obs_data);
      end
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   task automatic test_stats();
      logic [NREQ*32-1:0] exp_beats;
      do_reset();
      q[0].push_back({1'b0, 32'h10}); q[0].push_back({1'b1, 32'h11});
      q[1].push_back({1'b0, 32'h20}); q[1].push_back({1'b1, 32'h21});
      q[3].push_back({1'b0, 32'h30}); q[3].push_back({1'b1, 32'h31});
      for (int c = 0; c < 14; c++) begin
         full_next = (c >= 4 && c <= 8);
         run_cycle();
      end
      full_next = 1'b0;
      @(negedge clock);
      exp_beats = {32'd2, 32'd0, 32'd2, 32'd2};
      tests_run++;
      if (stat_beats !== exp_beats) begin
         tests_failed++;
         $display("FAIL stats_beats: got %h expected %h", stat_beats, exp_beats);
      end
      tests_run++;
      if (stat_stall !== 32'd5) begin
         tests_failed++;
         $display("FAIL stats_stall: got %0d expected 5", stat_stall);
      end
   endtask
`endif

   function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic test_random();
      int              m_owner, m_cnt, m_ptr, w, n, r;
      logic            m_grant, acc, rel;
      logic [NREQ-1:0] exp_ready;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] sb [NREQ][$];
      do_reset();
      m_grant = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(4) == 0) begin
            r = $urandom_range(NREQ - 1);
            n = $urandom_range(12, 1);
            for (int k = 0; k < n; k++) begin
               d = $urandom;
               q[r].push_back({k == n - 1, d});
               sb[r].push_back(d);
            end
         end
         hold      = ($urandom_range(9) == 0) ? NREQ'($urandom) : '0;
         full_next = ($urandom_range(4) == 0);
         run_cycle();

         acc       = m_grant && req_valid[m_owner] && !fifo_full;
         exp_ready = (m_grant && !fifo_full) ? NREQ'(1 << m_owner) : '0;
         tests_run++;
         if (obs_gv !== m_grant || obs_id !== IDW'(m_owner) || obs_en !== acc || obs_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL random c%0d: gv=%b id=%0d en=%b ready=%b expected gv=%b id=%0d en=%b ready=%b",
                     c, obs_gv, obs_id, obs_en, obs_ready, m_grant, m_owner, acc, exp_ready);
         end
         if (obs_en === 1'b1 && !$isunknown(obs_id)) begin
            tests_run++;
            if (sb[obs_id].size() == 0 || obs_data !== sb[obs_id][0]) begin
               tests_failed++;
               $display("FAIL random_data c%0d: id=%0d got %h expected %h", c, obs_id, obs_data,
                        (sb[obs_id].size() == 0) ? '0 : sb[obs_id][0]);
            end
            if (sb[obs_id].size() != 0) void'(sb[obs_id].pop_front());
         end

         if (!m_grant) begin
            w = ref_pick(req_valid, m_ptr);
            if (w >= 0) begin m_grant = 1'b1; m_owner = w; m_cnt = 0; end
         end else begin
            rel = !req_valid[m_owner] || (acc && (req_last[m_owner] || m_cnt == MAX_BURST - 1));
            if (acc) m_cnt++;
            if (rel) begin
               m_ptr = (m_owner + 1) % NREQ;
               w     = ref_pick(req_valid, m_ptr);
               m_cnt = 0;
               if (w >= 0 && w != m_owner) m_owner = w;
               else m_grant = 1'b0;
            end
         end
      end
      full_next = 1'b0;
      hold      = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_max_burst();
      test_full_stall();
      test_drop_valid();
      test_reset_mid_burst();
`ifdef FIFO_WR_ARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
